instruction_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the Harvard machine core. It owns the program counter and instruction register, and steps the instruction ROM, decoder, ALU/accumulator and data memory through fixed phases. It handles the data-memory ready handshake, jump/jump-if-zero and halt. It sits between the instruction ROM and the decoder stage and issues all per-phase enables.

---
 rtl/instruction_sequencer_pkg.sv | 33 +++
 rtl/instruction_sequencer_pc_unit.sv | 34 +++
 rtl/instruction_sequencer.sv | 150 +++++++++++++++
 tb/tb_instruction_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state codes, opcode
// constants, instruction field positions and a small opcode classifier.
package instruction_sequencer_pkg;

  // State codes are visible on StateOutput, so the encoding is fixed.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  localparam logic [4:0] OPC_NOP  = 5'b00000;
  localparam logic [4:0] OPC_JMP  = 5'b11000;
  localparam logic [4:0] OPC_JZ   = 5'b11001;
  localparam logic [4:0] OPC_HALT = 5'b11111;

  // Instruction word layout: [21:17] opcode, [16] mode, [15:0] operand.
  localparam int INSTR_WIDTH = 22;
  localparam int OPC_MSB     = 21;
  localparam int OPC_LSB     = 17;
  localparam int MODE_BIT    = 16;
  localparam int OPERAND_LSB = 0;

  // Control-flow and no-op instructions leave the accumulator untouched.
  function automatic logic writes_acc(input logic [4:0] opcode);
    return !((opcode == OPC_NOP) || (opcode == OPC_JMP) || (opcode == OPC_JZ));
  endfunction

endpackage

// File: rtl/instruction_sequencer_pc_unit.sv
// Program counter for the instruction sequencer.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_load        load i_target into the PC (taken jump)
//   i_inc         advance the PC by one, wrapping at 2^PC_WIDTH
//   i_target      jump target (operand low bits)
//   o_pc          current program counter
module instruction_sequencer_pc_unit #(
  parameter int PC_WIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic                i_inc,
  input  logic [PC_WIDTH-1:0] i_target,
  output logic [PC_WIDTH-1:0] o_pc
);

  logic [PC_WIDTH-1:0] r_pc;

  // Load has priority; the FSM never raises both, but a jump must win.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_WIDTH'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller of the Harvard core. Owns the instruction
// register and memory wait counter, drives the PC unit and issues one
// registered enable per phase.
// Ports:
//   ClockInput, ResetInput        clock, asynchronous active-high reset
//   RunInput                      start / continue at instruction boundaries
//   InstructionInput              ROM word addressed by ProgramCounterOutput
//   AccZeroInput                  accumulator-is-zero flag (for JZ)
//   DataReadyInput                data memory access complete
//   ProgramCounterOutput          ROM address
//   InstructionRegisterOutput     latched instruction for the decoder
//   Fetch/Decode/ExecuteEnable    phase enables
//   DataRequestOutput             data memory request (MEMORY phase)
//   AccWriteEnableOutput          accumulator write strobe (WRITEBACK)
//   HaltedOutput, FaultOutput     halted state, memory timeout seen
//   StateOutput                   current state code
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int PC_WIDTH       = 8,
  parameter int MEM_WAIT_LIMIT = 15
) (
  input  logic                   ClockInput,
  input  logic                   ResetInput,
  input  logic                   RunInput,
  input  logic [INSTR_WIDTH-1:0] InstructionInput,
  input  logic                   AccZeroInput,
  input  logic                   DataReadyInput,
  output logic [PC_WIDTH-1:0]    ProgramCounterOutput,
  output logic [INSTR_WIDTH-1:0] InstructionRegisterOutput,
  output logic                   FetchEnableOutput,
  output logic                   DecodeEnableOutput,
  output logic                   ExecuteEnableOutput,
  output logic                   DataRequestOutput,
  output logic                   AccWriteEnableOutput,
  output logic                   HaltedOutput,
  output logic                   FaultOutput,
  output logic [2:0]             StateOutput
);

  localparam int WAIT_W = $clog2(MEM_WAIT_LIMIT + 1);
  // Counter value during the last permitted MEMORY cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_LIMIT - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic [WAIT_W-1:0]      r_wait;
  logic                   r_fetch_en;
  logic                   r_decode_en;
  logic                   r_exec_en;
  logic                   r_data_req;
  logic                   r_acc_we;
  logic                   r_halted;
  logic                   r_fault;
  logic                   w_fault_set;
  logic                   w_pc_load;
  logic                   w_pc_inc;
  logic [4:0]             w_opcode;
  logic                   w_mode;

  assign w_opcode = r_ir[OPC_MSB:OPC_LSB];
  assign w_mode   = r_ir[MODE_BIT];

  always_comb begin
    w_state_next = r_state;
    w_fault_set  = 1'b0;
    w_pc_load    = 1'b0;
    w_pc_inc     = 1'b0;
    case (r_state)
      ST_IDLE:   if (RunInput) w_state_next = ST_FETCH;
      ST_FETCH:  w_state_next = ST_DECODE;
      ST_DECODE: w_state_next = ST_EXECUTE;
      ST_EXECUTE: begin
        if (w_opcode == OPC_HALT) w_state_next = ST_HALT;
        else if (w_mode)          w_state_next = ST_MEMORY;
        else                      w_state_next = ST_WRITEBACK;
      end
      ST_MEMORY: begin
        // Ready is checked first so a late response on the last cycle wins.
        if (DataReadyInput) begin
          w_state_next = ST_WRITEBACK;
        end else if (r_wait == WAIT_LAST) begin
          w_state_next = ST_HALT;
          w_fault_set  = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        if (w_opcode == OPC_JMP)                       w_pc_load = 1'b1;
        else if ((w_opcode == OPC_JZ) && AccZeroInput) w_pc_load = 1'b1;
        else                                           w_pc_inc  = 1'b1;
        w_state_next = RunInput ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: w_state_next = ST_HALT;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ClockInput or posedge ResetInput) begin
    if (ResetInput) begin
      r_state     <= ST_IDLE;
      r_ir        <= '0;
      r_wait      <= '0;
      r_fetch_en  <= 1'b0;
      r_decode_en <= 1'b0;
      r_exec_en   <= 1'b0;
      r_data_req  <= 1'b0;
      r_acc_we    <= 1'b0;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_FETCH) r_ir <= InstructionInput;
      // Counts MEMORY cycles already spent; cleared whenever MEMORY is left.
      if ((r_state == ST_MEMORY) && (w_state_next == ST_MEMORY)) r_wait <= r_wait + WAIT_W'(1);
      else                                                       r_wait <= '0;
      // Enables are registered from the next state so they line up exactly
      // with the state they belong to.
      r_fetch_en  <= (w_state_next == ST_FETCH);
      r_decode_en <= (w_state_next == ST_DECODE);
      r_exec_en   <= (w_state_next == ST_EXECUTE);
      r_data_req  <= (w_state_next == ST_MEMORY);
      r_acc_we    <= (w_state_next == ST_WRITEBACK) && writes_acc(w_opcode);
      r_halted    <= (w_state_next == ST_HALT);
      r_fault     <= r_fault | w_fault_set;
    end
  end

  instruction_sequencer_pc_unit #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_unit (
    .i_clk    (ClockInput),
    .i_rst    (ResetInput),
    .i_load   (w_pc_load),
    .i_inc    (w_pc_inc),
    .i_target (r_ir[OPERAND_LSB +: PC_WIDTH]),
    .o_pc     (ProgramCounterOutput)
  );

  assign InstructionRegisterOutput = r_ir;
  assign FetchEnableOutput         = r_fetch_en;
  assign DecodeEnableOutput        = r_decode_en;
  assign ExecuteEnableOutput       = r_exec_en;
  assign DataRequestOutput         = r_data_req;
  assign AccWriteEnableOutput      = r_acc_we;
  assign HaltedOutput              = r_halted;
  assign FaultOutput               = r_fault;
  assign StateOutput               = r_state;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer. An instruction-level model
// expands each fetched ROM word into the expected list of per-cycle state
// codes and updates the PC at the end of the instruction; every cycle the
// DUT outputs are compared against it. Directed episodes add literal checks.
module tb_instruction_sequencer;

  localparam int LIMIT = 15;
  localparam logic [4:0] T_NOP  = 5'b00000;
  localparam logic [4:0] T_JMP  = 5'b11000;
  localparam logic [4:0] T_JZ   = 5'b11001;
  localparam logic [4:0] T_HALT = 5'b11111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        acc_zero = 1'b0;
  logic        ready = 1'b0;
  logic [21:0] instr;
  logic [7:0]  pc;
  logic [21:0] ir;
  logic        fe, de, ee, dr, aw, ht, ft;
  logic [2:0]  st;

  logic [21:0] rom [256];

  always #5 clk = ~clk;
  assign instr = rom[pc];

  instruction_sequencer #(
    .PC_WIDTH(8),
    .MEM_WAIT_LIMIT(LIMIT)
  ) dut (
    .ClockInput(clk),
    .ResetInput(rst),
    .RunInput(run),
    .InstructionInput(instr),
    .AccZeroInput(acc_zero),
    .DataReadyInput(ready),
    .ProgramCounterOutput(pc),
    .InstructionRegisterOutput(ir),
    .FetchEnableOutput(fe),
    .DecodeEnableOutput(de),
    .ExecuteEnableOutput(ee),
    .DataRequestOutput(dr),
    .AccWriteEnableOutput(aw),
    .HaltedOutput(ht),
    .FaultOutput(ft),
    .StateOutput(st)
  );

  int checks = 0;
  int errors = 0;

  // model state
  int          m_state;
  logic [7:0]  m_pc;
  logic [21:0] m_ir;
  bit          m_fault;
  bit          m_fault_pending;
  int          q[$];
  int          k_plan, k_fixed, mcount;
  int          run_pol, az_pol;
  int          cyc;
  int          hist_st[64], hist_pc[64], hist_req[64], hist_aw[64], hist_ft[64], hist_ht[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic acc_written(input logic [4:0] op);
    return (op != T_NOP) && (op != T_JMP) && (op != T_JZ);
  endfunction

  function automatic int rand_k();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4) return LIMIT + 1 + r;   // never answered: timeout
    if (r < 9) return LIMIT;           // answered on the very last cycle
    return $urandom_range(1, 6);
  endfunction

  task automatic model_reset();
    m_state = 0; m_pc = '0; m_ir = '0; m_fault = 0; m_fault_pending = 0;
    q.delete(); mcount = 0; cyc = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, st, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_enables"}, {fe, de, ee, dr, aw}, 0);
    chk({tag, "_halt_fault"}, {ht, ft}, 0);
  endtask

  task automatic check_outputs();
    chk("state", st, m_state);
    chk("pc", pc, m_pc);
    chk("ir", ir, m_ir);
    chk("fetch_en", fe, m_state == 1);
    chk("decode_en", de, m_state == 2);
    chk("exec_en", ee, m_state == 3);
    chk("data_req", dr, m_state == 4);
    chk("acc_we", aw, (m_state == 5) && acc_written(m_ir[21:17]));
    chk("halted", ht, m_state == 6);
    chk("fault", ft, m_fault);
  endtask

  // Advance the model across the coming clock edge using the inputs just driven.
  task automatic advance_model();
    logic [21:0] w;
    int k, n;
    if (m_state == 6) return;
    if (q.size() > 0) begin
      if (m_state == 1) m_ir = rom[m_pc];
      m_state = q.pop_front();
      if (m_state == 6 && m_fault_pending) m_fault = 1;
      return;
    end
    // instruction boundary: end of WRITEBACK or waiting in IDLE
    if (m_state == 5) begin
      if (m_ir[21:17] == T_JMP)                   m_pc = m_ir[7:0];
      else if (m_ir[21:17] == T_JZ && acc_zero)   m_pc = m_ir[7:0];
      else                                        m_pc = m_pc + 8'd1;
    end
    if (!run) begin
      m_state = 0;
      return;
    end
    w = rom[m_pc];
    q.push_back(2);
    q.push_back(3);
    if (w[21:17] == T_HALT) begin
      q.push_back(6);
    end else if (w[16]) begin
      k = (k_fixed > 0) ? k_fixed : rand_k();
      k_plan = k;
      n = (k <= LIMIT) ? k : LIMIT;
      for (int i = 0; i < n; i++) q.push_back(4);
      if (k <= LIMIT) q.push_back(5);
      else begin
        q.push_back(6);
        m_fault_pending = 1;
      end
    end else begin
      q.push_back(5);
    end
    m_state = 1;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (cyc < 64) begin
      hist_st[cyc] = int'(st); hist_pc[cyc] = int'(pc); hist_req[cyc] = int'(dr);
      hist_aw[cyc] = int'(aw); hist_ft[cyc] = int'(ft); hist_ht[cyc] = int'(ht);
    end
    // data memory: answer on the k-th requested cycle, noise otherwise
    if (dr) begin
      mcount++;
      ready = (mcount == k_plan);
    end else begin
      mcount = 0;
      ready = 1'($urandom_range(0, 1));
    end
    case (run_pol)
      0: run = 1'b0;
      1: run = 1'b1;
      2: run = ($urandom_range(0, 9) != 0);
      default: run = ~run;
    endcase
    case (az_pol)
      0: acc_zero = 1'b0;
      1: acc_zero = 1'b1;
      default: acc_zero = 1'($urandom_range(0, 1));
    endcase
    advance_model();
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    #1;
    check_zero("reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [21:0] mk(input logic [4:0] op, input logic mode, input logic [15:0] opnd);
    return {op, mode, opnd};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  initial begin
    int cnt;
    int r;
    logic [4:0] op;
    k_fixed = 0; k_plan = 0; run_pol = 1; az_pol = 2;

    // ---- D1: basic, memory operand, jumps, PC wrap ----
    clear_rom();
    rom[0]     = mk(5'b00010, 1'b0, 16'h0000);
    rom[1]     = mk(5'b00011, 1'b1, 16'h0042);
    rom[2]     = mk(T_NOP,    1'b0, 16'h0000);
    rom[3]     = mk(5'b00100, 1'b0, 16'h0007);
    rom[4]     = mk(T_JMP,    1'b0, 16'h0123);
    rom[8'h23] = mk(T_JZ,     1'b0, 16'h0050);
    rom[8'h50] = mk(T_JZ,     1'b0, 16'h0077);
    rom[8'h51] = mk(T_JMP,    1'b0, 16'h00FF);
    rom[8'hFF] = mk(5'b00101, 1'b0, 16'h0000);
    k_fixed = 3; run_pol = 1; az_pol = 1;
    apply_reset();
    repeat (28) cycle();
    az_pol = 0;
    repeat (16) cycle();
    chk("d1_fetch_state", hist_st[1], 1);
    chk("d1_decode_state", hist_st[2], 2);
    chk("d1_exec_state", hist_st[3], 3);
    chk("d1_wb_state", hist_st[4], 5);
    chk("d1_acc_pulse", {hist_aw[3][0], hist_aw[4][0], hist_aw[5][0]}, 3'b010);
    chk("d1_next_fetch", hist_st[5], 1);
    chk("d1_pc_after_first", hist_pc[5], 1);
    cnt = 0;
    for (int i = 5; i < 12; i++) cnt += hist_req[i];
    chk("d1_mem_req_cycles", cnt, 3);
    chk("d1_mem_wb", hist_st[11], 5);
    chk("d1_nop_no_acc", hist_aw[15], 0);
    chk("d1_jmp_no_acc", hist_aw[23], 0);
    chk("d1_jmp_pc", hist_pc[24], 8'h23);
    chk("d1_jz_taken_pc", hist_pc[28], 8'h50);
    chk("d1_jz_not_taken_pc", hist_pc[32], 8'h51);
    chk("d1_jmp_ff_pc", hist_pc[36], 8'hFF);
    chk("d1_pc_wrap", hist_pc[40], 8'h00);

    // ---- D2: HALT holds regardless of RunInput ----
    clear_rom();
    rom[0] = mk(T_HALT, 1'b1, 16'h1234);
    k_fixed = 0; run_pol = 3; az_pol = 2;
    apply_reset();
    repeat (26) cycle();
    chk("d2_halt_state", hist_st[4], 6);
    cnt = 0;
    for (int i = 4; i < 24; i++) if (hist_st[i] != 6 || hist_ht[i] != 1 || hist_ft[i] != 0) cnt++;
    chk("d2_halt_hold", cnt, 0);

    // ---- D3: memory timeout ----
    clear_rom();
    rom[0] = mk(5'b00011, 1'b1, 16'h0010);
    k_fixed = 99; run_pol = 1;
    apply_reset();
    repeat (25) cycle();
    cnt = 0;
    for (int i = 0; i < 25; i++) cnt += hist_req[i];
    chk("d3_mem_cycles", cnt, LIMIT);
    chk("d3_last_mem", hist_st[18], 4);
    chk("d3_fault_halt", {hist_st[19][2:0], hist_ft[18][0], hist_ft[19][0]}, {3'd6, 1'b0, 1'b1});

    // ---- D4: ready on the last permitted cycle wins ----
    k_fixed = LIMIT;
    apply_reset();
    repeat (22) cycle();
    chk("d4_ready_wins", {hist_st[19][2:0], hist_ft[19][0]}, {3'd5, 1'b0});
    chk("d4_next_fetch_pc", {hist_st[20][2:0], hist_pc[20][7:0]}, {3'd1, 8'd1});

    // ---- D5: asynchronous reset in MEMORY ----
    k_fixed = 99;
    apply_reset();
    repeat (6) cycle();
    chk("d5_in_memory", hist_st[5], 4);
    @(posedge clk);
    #2;
    rst = 1'b1; run = 1'b0;
    #1;
    check_zero("async");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_pol = 0;
    repeat (3) cycle();

    // ---- Random episodes ----
    for (int ep = 0; ep < 8; ep++) begin
      for (int a = 0; a < 256; a++) begin
        r = $urandom_range(0, 999);
        if (r < 150)      op = T_JMP;
        else if (r < 300) op = T_JZ;
        else if (r < 400) op = T_NOP;
        else if (r < 405) op = T_HALT;
        else              op = 5'($urandom_range(1, 23));
        rom[a] = mk(op, ($urandom_range(0, 9) < 3), 16'($urandom));
      end
      k_fixed = 0; run_pol = 2; az_pol = 2;
      apply_reset();
      repeat (300) cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
